// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for multi_mode_counter and the lab blocks that reuse it.
//   Contents:
//     MODE_BIN / MODE_GRAY / MODE_JOHN / MODE_ONEHOT : 2-bit code-mode selectors
//     is_arith()                                    : true for the two modes whose
//                                                     state register holds a plain
//                                                     binary count (binary, Gray)
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic [1:0] MODE_BIN    = 2'b00;
  localparam logic [1:0] MODE_GRAY   = 2'b01;
  localparam logic [1:0] MODE_JOHN   = 2'b10;
  localparam logic [1:0] MODE_ONEHOT = 2'b11;

  // Binary and Gray share an arithmetic state register; saturation and the
  // all-ones/zero terminal-count decode only make sense for these two.
  function automatic logic is_arith(input logic [1:0] mode);
    return (mode == MODE_BIN) || (mode == MODE_GRAY);
  endfunction

endpackage : counter_pkg

// File: rtl/bin2gray.sv
// -----------------------------------------------------------------------------
// bin2gray
//   Combinational binary-to-reflected-Gray converter.
//   Parameters:
//     WIDTH   code width in bits
//   Ports:
//     i_bin   in   WIDTH  binary value
//     o_gray  out  WIDTH  Gray-coded value (i_bin ^ (i_bin >> 1))
// -----------------------------------------------------------------------------
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule : bin2gray

// File: rtl/multi_mode_counter.sv
// -----------------------------------------------------------------------------
// multi_mode_counter
//   WIDTH-bit sequencer/timebase with four output codes (binary, Gray,
//   Johnson, one-hot ring), direction, enable, parallel load, optional
//   saturation, terminal-count decode and a registered wrap pulse.
//   Parameters:
//     WIDTH     counter width, >= 2
//     SAT_EN    1 = sat input honoured in binary/Gray; 0 = always wrap
//   Ports:
//     clk       in   1      rising-edge clock
//     n_rst     in   1      asynchronous active-low reset
//     en        in   1      advance one step per clock while high
//     up        in   1      1 = up/left, 0 = down/right
//     mode      in   2      code select (see counter_pkg)
//     load      in   1      synchronous parallel load strobe
//     load_val  in   WIDTH  raw value written to the state register on load
//     sat       in   1      binary/Gray: hold at the end value instead of wrapping
//     out       out  WIDTH  counter value in the selected code
//     tc        out  1      terminal count, combinational on out and up
//     wrap      out  1      one-cycle pulse on the cycle after a wrap
// -----------------------------------------------------------------------------
module multi_mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_mode_q;
  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] w_step;
  logic             w_tc;
  logic             w_sat_hold;
  logic [1:0]       w_mode_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .i_bin  (r_q),
    .o_gray (w_gray)
  );

  // Only Gray mode re-encodes; Johnson and one-hot keep the raw code in r_q.
  assign out  = (r_mode_q == MODE_GRAY) ? w_gray : r_q;
  assign tc   = w_tc;
  assign wrap = r_wrap;

  // Terminal count: the last value before the sequence returns to its start
  // in the current direction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_tc = 1'b0;
    case (r_mode_q)
      MODE_BIN, MODE_GRAY: w_tc = up ? (&r_q) : ~(|r_q);
      MODE_JOHN:           w_tc = up ? (r_q == MSB) : (r_q == ONE);
      MODE_ONEHOT:         w_tc = up ? r_q[WIDTH-1] : r_q[0];
      default:             w_tc = 1'b0;
    endcase
  end

  // One enabled step in the current mode and direction.
  always_comb begin
    w_step = r_q;
    case (r_mode_q)
      MODE_BIN, MODE_GRAY: w_step = up ? (r_q + ONE) : (r_q - ONE);
      MODE_JOHN:   w_step = up ? {r_q[WIDTH-2:0], ~r_q[WIDTH-1]}
                               : {~r_q[0], r_q[WIDTH-1:1]};
      MODE_ONEHOT: w_step = up ? {r_q[WIDTH-2:0], r_q[WIDTH-1]}
                               : {r_q[0], r_q[WIDTH-1:1]};
      default:     w_step = r_q;
    endcase
  end

  // At the end value of an arithmetic mode with saturation requested the
  // count freezes, which also suppresses the wrap pulse.
  assign w_sat_hold = SAT_EN && sat && is_arith(r_mode_q) && w_tc;

  // Priority: mode change > load > enabled step > hold.
  always_comb begin
    w_mode_next = r_mode_q;
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (mode != r_mode_q) begin
      w_mode_next = mode;
      w_q_next    = (mode == MODE_ONEHOT) ? ONE : '0;
    end else if (load) begin
      w_q_next = load_val;
    end else if (en && !w_sat_hold) begin
      w_q_next    = w_step;
      w_wrap_next = w_tc;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_mode_q <= MODE_BIN;
      r_q      <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_mode_q <= w_mode_next;
      r_q      <= w_q_next;
      r_wrap   <= w_wrap_next;
    end
  end

endmodule : multi_mode_counter

// File: tb/tb_multi_mode_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_mode_counter
//   Directed, table-driven bench for multi_mode_counter (WIDTH=4, SAT_EN=1).
//   Each table row holds the inputs applied for one clock and the out/tc/wrap
//   values expected just after that edge; hand-written sequences cover reset.
// -----------------------------------------------------------------------------
module tb_multi_mode_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         sat = 1'b0;
  logic [W-1:0] out;
  logic         tc;
  logic         wrap;

  int n_vec = 0;
  int n_err = 0;

  multi_mode_counter #(.WIDTH(W), .SAT_EN(1'b1)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (en),
    .up       (up),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .sat      (sat),
    .out      (out),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic         up;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_val;
    logic         sat;
    logic [W-1:0] exp_out;
    logic         exp_tc;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic u, input logic [1:0] m,
                     input logic ld, input logic [W-1:0] lv, input logic s,
                     input logic [W-1:0] o, input logic t, input logic w);
    vec_t v;
    v.en = e; v.up = u; v.mode = m; v.load = ld; v.load_val = lv; v.sat = s;
    v.exp_out = o; v.exp_tc = t; v.exp_wrap = w;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- table ------------------------------------------- en up md ld lv   sat  out   tc wr
    // Binary up through a full period, wrap only after 15 -> 0.
    add(1,1,2'b00,0,4'h0,0, 4'd1, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd2, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd3, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd4, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd5, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd6, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd7, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd8, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd9, 0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd10,0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd11,0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd12,0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd13,0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd14,0,0);
    add(1,1,2'b00,0,4'h0,0, 4'd15,1,0);
    add(1,1,2'b00,0,4'h0,0, 4'd0, 0,1);
    add(1,1,2'b00,0,4'h0,0, 4'd1, 0,0);
    add(0,1,2'b00,0,4'h0,0, 4'd1, 0,0);   // en low: hold
    // Gray: mode change seeds 0 and ignores en, then 7 steps.
    add(1,1,2'b01,0,4'h0,0, 4'b0000,0,0);
    add(1,1,2'b01,0,4'h0,0, 4'b0001,0,0);
    add(1,1,2'b01,0,4'h0,0, 4'b0011,0,0);
    add(1,1,2'b01,0,4'h0,0, 4'b0010,0,0);
    add(1,1,2'b01,0,4'h0,0, 4'b0110,0,0);
    add(1,1,2'b01,0,4'h0,0, 4'b0111,0,0);
    add(1,1,2'b01,0,4'h0,0, 4'b0101,0,0);
    add(1,1,2'b01,0,4'h0,0, 4'b0100,0,0);
    add(0,1,2'b01,1,4'hF,0, 4'b1000,1,0);   // q=15 shows as 1000, tc
    add(1,1,2'b01,0,4'h0,0, 4'b0000,0,1);   // Gray wrap
    add(0,1,2'b01,1,4'hF,1, 4'b1000,1,0);
    add(1,1,2'b01,0,4'h0,1, 4'b1000,1,0);   // saturated up: hold, no wrap
    // Binary down with saturation from 2.
    add(0,0,2'b00,0,4'h0,1, 4'd0, 1,0);     // mode change, tc down at zero
    add(0,0,2'b00,1,4'h2,1, 4'd2, 0,0);
    add(1,0,2'b00,0,4'h0,1, 4'd1, 0,0);
    add(1,0,2'b00,0,4'h0,1, 4'd0, 1,0);
    add(1,0,2'b00,0,4'h0,1, 4'd0, 1,0);
    add(1,0,2'b00,0,4'h0,1, 4'd0, 1,0);
    add(1,0,2'b00,0,4'h0,0, 4'd15,0,1);     // sat dropped: wraps down
    // Load beats en on the same edge.
    add(1,1,2'b00,1,4'hA,0, 4'b1010,0,0);
    add(1,1,2'b00,0,4'h0,0, 4'b1011,0,0);
    // Johnson up, period 8, then reverse at 1100.
    add(1,1,2'b10,0,4'h0,0, 4'b0000,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b0001,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b0011,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b0111,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b1111,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b1110,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b1100,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b1000,1,0);
    add(1,1,2'b10,0,4'h0,0, 4'b0000,0,1);
    add(1,1,2'b10,0,4'h0,0, 4'b0001,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b0011,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b0111,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b1111,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b1110,0,0);
    add(1,1,2'b10,0,4'h0,0, 4'b1100,0,0);
    add(1,0,2'b10,0,4'h0,0, 4'b1110,0,0);   // reverse takes effect same edge
    add(1,0,2'b10,0,4'h0,0, 4'b1111,0,0);
    add(1,0,2'b10,0,4'h0,0, 4'b0111,0,0);
    add(1,0,2'b10,0,4'h0,0, 4'b0011,0,0);
    add(1,0,2'b10,0,4'h0,0, 4'b0001,1,0);
    add(1,0,2'b10,0,4'h0,0, 4'b0000,0,1);
    // One-hot: mode change mid-count with load and en both high.
    add(1,1,2'b11,1,4'hA,0, 4'b0001,0,0);
    add(1,1,2'b11,0,4'h0,0, 4'b0010,0,0);
    add(1,1,2'b11,0,4'h0,0, 4'b0100,0,0);
    add(1,1,2'b11,0,4'h0,0, 4'b1000,1,0);
    add(1,1,2'b11,0,4'h0,0, 4'b0001,0,1);
    add(1,0,2'b11,0,4'h0,0, 4'b1000,0,1);   // down from 0001 wraps right
    add(1,0,2'b11,0,4'h0,0, 4'b0100,0,0);
    add(1,0,2'b11,0,4'h0,0, 4'b0010,0,0);
    add(1,0,2'b11,0,4'h0,0, 4'b0001,1,0);
    add(1,0,2'b11,0,4'h0,0, 4'b1000,0,1);
    add(0,0,2'b11,1,4'hA,0, 4'b1010,0,0);   // illegal code loaded raw

    // ---- reset state --------------------------------------------------------
    #1 n_rst = 1'b0;
    #1;
    check("rst.out",  out,  4'b0000);
    check("rst.wrap", wrap, 1'b0);
    check("rst.tc_up", tc,  1'b0);
    up = 1'b0;
    #1;
    check("rst.tc_dn", tc,  1'b1);
    n_rst = 1'b1;

    // ---- table application --------------------------------------------------
    foreach (vecs[i]) begin
      en = vecs[i].en; up = vecs[i].up; mode = vecs[i].mode;
      load = vecs[i].load; load_val = vecs[i].load_val; sat = vecs[i].sat;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.out", i),  out,  vecs[i].exp_out);
      check($sformatf("v%0d.tc", i),   tc,   vecs[i].exp_tc);
      check($sformatf("v%0d.wrap", i), wrap, vecs[i].exp_wrap);
    end

    // ---- asynchronous reset mid-count from one-hot ---------------------------
    en = 1'b1; up = 1'b1; load = 1'b0; mode = 2'b11;
    @(posedge clk);
    #1;
    check("ar.pre_out",  out,  4'b0101);   // 1010 rotated left
    check("ar.pre_wrap", wrap, 1'b1);      // advanced while out[3]=1
    #3 n_rst = 1'b0;
    #1;
    check("ar.out",  out,  4'b0000);       // cleared without a clock edge
    check("ar.wrap", wrap, 1'b0);
    check("ar.tc",   tc,   1'b0);
    mode = 2'b00;
    @(posedge clk);
    #1;
    check("ar.held", out, 4'b0000);
    #2 n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("ar.first", out,  4'b0001);      // counts in binary: mode_q was reset
    check("ar.fwrap", wrap, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_multi_mode_counter
